// File: rtl/blur_frame_ctrl.sv
// Frame-level flow controller in front of the 3x3 box-blur core. It admits whole
// lines only while a ring-buffer slot is free and brackets each frame with busy/done.
module blur_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int NUM_LINES  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_pixel,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [DATA_WIDTH-1:0]          blur_pixel,
  output logic                           blur_valid,
  input  logic                           line_consumed,
  input  logic                           blur_out_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(NUM_LINES+1)-1:0] occupancy,
  output logic [2:0]                     state_dbg
);

  localparam int PIX_W  = $clog2(IMG_WIDTH);
  localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
  localparam int OUT_W  = $clog2(IMG_HEIGHT * IMG_WIDTH + 1);
  localparam int OCC_W  = $clog2(NUM_LINES + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] FILL_LINES = LINE_W'(3);
  localparam logic [LINE_W-1:0] LAST_LINES = LINE_W'(IMG_HEIGHT);
  localparam logic [OUT_W-1:0]  OUT_TOTAL  = OUT_W'((IMG_HEIGHT - 2) * IMG_WIDTH);
  localparam logic [OCC_W-1:0]  OCC_MAX    = OCC_W'(NUM_LINES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               err_q, err_d;
  logic               lc_q, lc_d;

  logic               line_open;
  logic               may_open;
  logic               accept;
  logic               opening;
  logic               line_end;
  logic               retire;
  logic               out_full;
  logic               counting;
  logic [LINE_W-1:0]  line_cnt_inc;

  // Source handshake: a pixel transfers on any cycle where s_valid and s_ready are
  // both high. s_ready depends on registered state only, so it never waits on s_valid.
  always_comb begin
    line_open    = (pix_cnt_q != '0);
    may_open     = (state_q == ST_FILL) ||
                   ((state_q == ST_STREAM) && (occ_q < OCC_MAX));
    s_ready      = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                   (line_open || may_open);
    accept       = s_valid && s_ready;
    opening      = accept && !line_open;
    line_end     = accept && (pix_cnt_q == PIX_LAST);
    retire       = line_consumed && !lc_q;
    out_full     = (out_cnt_q == OUT_TOTAL);
    counting     = (state_q == ST_FILL) || (state_q == ST_STREAM) ||
                   (state_q == ST_DRAIN);
    line_cnt_inc = line_cnt_q + LINE_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    occ_d      = occ_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;
    lc_d       = line_consumed;

    if (accept) begin
      if (line_end) begin
        pix_cnt_d  = '0;
        line_cnt_d = line_cnt_inc;
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end

    // Opening and retiring in the same cycle cancel; retiring an empty ring is an error.
    if (retire && (occ_q == '0)) begin
      err_d = 1'b1;
    end
    if (opening && !retire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (retire && !opening && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end

    if (blur_out_valid) begin
      if ((state_q == ST_IDLE) || out_full) begin
        err_d = 1'b1;
      end else if (counting) begin
        out_cnt_d = out_cnt_q + OUT_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FILL;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          occ_d      = '0;
          out_cnt_d  = '0;
          err_d      = 1'b0;
        end
      end
      ST_FILL: begin
        if (line_end && (line_cnt_inc == LAST_LINES)) begin
          state_d = ST_DRAIN;
        end else if (line_end && (line_cnt_inc == FILL_LINES)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (line_end && (line_cnt_inc == LAST_LINES)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == OUT_TOTAL) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      occ_q      <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      lc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      occ_q      <= occ_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      lc_q       <= lc_d;
    end
  end

  assign blur_pixel = s_pixel;
  assign blur_valid = accept;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign occupancy  = occ_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/blur_frame_ctrl.md
# blur_frame_ctrl

Frame-level flow controller placed in front of the 3x3 box-blur datapath (four-line ring buffer plus MAC). It accepts a raw pixel stream with valid/ready, and forwards whole image lines into the blur core only while a line slot is free. It retires slots on the core's per-line read-complete pulse and counts blurred output pixels to detect end of frame. Its purpose is to guarantee that the four-line buffer never overflows and that each frame is bracketed by start/done.

## Interface
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 512, pixels per line (>= 4)
- IMG_HEIGHT, 512, lines per frame (>= 3)
- NUM_LINES, 4, line slots in the blur core's ring buffer
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle frame start request; ignored unless IDLE
- s_pixel  input  DATA_WIDTH  source pixel
- s_valid  input  1  source pixel valid
- s_ready  output  1  controller accepts s_pixel this cycle
- blur_pixel  output  DATA_WIDTH  pixel to blur core (= s_pixel)
- blur_valid  output  1  pixel write strobe to blur core
- line_consumed  input  1  blur core read-complete indication; level, used on rising edge
- blur_out_valid  input  1  blur core output pixel valid
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle end-of-frame pulse
- err  output  1  sticky protocol error
- occupancy  output  $clog2(NUM_LINES+1)  line slots started and not yet retired

## Operation
- States: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE: s_ready=0. start=1 -> FILL; clears line/pixel/output counters and occupancy.
- A line is open from its first accepted pixel until IMG_WIDTH pixels are accepted. Opening a line increments occupancy.
- FILL: a new line may open unconditionally. When 3 lines are complete -> STREAM.
- STREAM: a new line may open only if occupancy < NUM_LINES. Mid-line, acceptance never stalls for credit. After line IMG_HEIGHT-1 completes -> DRAIN.
- DRAIN: s_ready=0. Wait until the output count reaches (IMG_HEIGHT-2)*IMG_WIDTH -> DONE.
- DONE: done=1 for one cycle, busy drops, then -> IDLE.
- s_ready = (FILL or STREAM) and (line open or a new line may open). blur_valid = s_valid & s_ready. blur_pixel = s_pixel. The forward path is combinational.
- line_consumed edge detect: a registered copy is compared with the input, so a held level counts once.
- Each rising edge decrements occupancy.
- A rising edge while occupancy=0 sets err and occupancy stays 0.
- A line open and a retire in the same cycle leave occupancy net unchanged.
- The output counter increments on blur_out_valid in FILL/STREAM/DRAIN.
- blur_out_valid in IDLE, or once the count already equals (IMG_HEIGHT-2)*IMG_WIDTH, sets err and is not counted.
- Counters: pixel-in-line $clog2(IMG_WIDTH) bits, wraps to 0 at IMG_WIDTH-1. Line counter $clog2(IMG_HEIGHT+1) bits. Output counter $clog2(IMG_HEIGHT*IMG_WIDTH+1) bits. No other wrap is permitted.
- err clears only on rst or on start acceptance.

## Timing
- Reset values: s_ready=0, blur_valid=0, busy=0, done=0, err=0, occupancy=0, state IDLE.
- Reset mid-frame discards all progress in the same cycle; the blur core is reset by the same rst.
- start accepted at edge N: busy=1 and s_ready can be 1 in cycle N+1.
- Forward latency is 0 cycles; s_ready is a function of registered state only, with no dependence on s_valid.
- Occupancy update is visible the cycle after the opening pixel or edge.
- A slot freed at edge N allows a new line in cycle N+1 if the edge arrives while blocked at occupancy=NUM_LINES.
- The final blur_out_valid at edge N moves to DONE. done=1 in cycle N+1 and busy=0 from cycle N+2.
- start coinciding with done is ignored.

## Test plan
- W=8, H=6, continuous s_valid, line_consumed pulsed after each 8 output pixels -> 48 blur_valid, 32 counted outputs, single done pulse, err=0.
- Hold line_consumed low after fill -> exactly 4 lines (32 pixels) accepted, s_ready=0 with occupancy=4. One pulse -> exactly 8 more pixels accepted.
- line_consumed held high for 20 cycles -> occupancy decrements by exactly 1.
- line_consumed pulse while occupancy=0 -> err=1 and stays 1 until the next start, occupancy=0.
- s_valid toggling every other cycle mid-line -> no lost or duplicated pixels, blur_pixel equals s_pixel on every strobe.
- rst asserted during line 3 -> next cycle all outputs at reset values. A fresh start then completes a normal frame.
